// File: rtl/mem_stage_responder.sv
// mem_stage_responder: multi-cycle byte/word data memory behind the MEM stage.
// One request in flight; fixed-latency response pulse with error flag.
module mem_stage_responder #(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH_BYTES);
  localparam logic [16:0] DEPTH_L  = 17'(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [7:0]  mem [DEPTH_BYTES];

  logic          accept;
  logic          enter_resp;
  logic          acc_write;
  logic [1:0]    acc_size;
  logic [15:0]   acc_addr;
  logic [15:0]   acc_wdata;
  logic          is_zx;
  logic          is_sx;
  logic          is_byte;
  logic          acc_err;
  logic [16:0]   addr_x;
  logic [AW-1:0] idx0;
  logic [AW-1:0] idx1;
  logic [15:0]   rd_data;

  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // With unit latency the access uses the live request on the accept edge
  assign enter_resp = (LATENCY == 1) ? accept
                                     : (state == WAIT && cnt == 4'd1);

  assign acc_write = (state == IDLE) ? req_write : wr_q;
  assign acc_size  = (state == IDLE) ? req_size  : size_q;
  assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

  assign is_zx   = (acc_size == 2'b01);
  assign is_sx   = (acc_size == 2'b10);
  assign is_byte = is_zx | is_sx;
  assign addr_x  = {1'b0, acc_addr};

  assign acc_err = (addr_x >= DEPTH_L) ||
                   (!is_byte && (acc_addr[0] ||
                                 (addr_x + 17'd1 >= DEPTH_L)));

  assign idx0 = acc_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      is_zx:   rd_data = {8'h00, mem[idx0]};
      is_sx:   rd_data = {{8{mem[idx0][7]}}, mem[idx0]};
      default: rd_data = {mem[idx1], mem[idx0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_q       <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_INIT;
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd1) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_error <= acc_err;
        resp_rdata <= (acc_err || acc_write) ? 16'h0000 : rd_data;
        if (!acc_err && acc_write) begin
          mem[idx0] <= acc_wdata[7:0];
          if (!is_byte) mem[idx1] <= acc_wdata[15:8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_responder.sv
// tb_mem_stage_responder: scoreboard bench for two responders
// (LATENCY=2 and LATENCY=1) against a byte-array reference model.
module tb_mem_stage_responder;

  logic        clk = 1'b0;
  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [1:0]  req_size   [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [15:0] resp_rdata [2];
  logic        resp_error [2];
  logic        busy       [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_stage_responder #(
      .DEPTH_BYTES(256),
      .LATENCY    ((g == 0) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_error(resp_error[g]),
      .busy      (busy[g])
    );
  end

  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mm [2][256];
  int         cyc    = 0;
  int         checks = 0;
  int         passed = 0;

  always @(posedge clk) cyc++;

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the array as plain bytes, rules applied with integer arithmetic
  task automatic model(input int d, input bit w, input bit [1:0] sz,
                       input bit [15:0] a, input bit [15:0] wd,
                       output logic [15:0] rd, output logic e);
    bit byt;
    int ai;
    byt = (sz == 2'd1) || (sz == 2'd2);
    ai  = int'(a);
    e   = (ai >= 256) || (!byt && ((ai % 2) == 1 || ai + 1 >= 256));
    rd  = 16'h0000;
    if (!e) begin
      if (w) begin
        mm[d][ai] = wd[7:0];
        if (!byt) mm[d][ai+1] = wd[15:8];
      end else if (!byt) begin
        rd = 16'(int'(mm[d][ai+1]) * 256 + int'(mm[d][ai]));
      end else if (sz == 2'd1) begin
        rd = 16'(mm[d][ai]);
      end else begin
        rd = (mm[d][ai] >= 8'd128) ? (16'hFF00 + 16'(mm[d][ai]))
                                   : 16'(mm[d][ai]);
      end
    end
  endtask

  task automatic issue(input int d, input bit w, input bit [1:0] sz,
                       input bit [15:0] a, input bit [15:0] wd,
                       input bit expect_resp, output int acc);
    exp_t x;
    int   n;
    n            = 0;
    req_write[d] = w;
    req_size[d]  = sz;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    while (!req_ready[d] && n < 40) begin
      tick();
      n++;
    end
    if (!req_ready[d]) begin
      check("accept_timeout", 0, 1);
      req_valid[d] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (expect_resp) begin
      model(d, w, sz, a, wd, x.rd, x.err);
      x.acc = acc;
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    tick();
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain_pending", q0.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset[d]) begin
        check($sformatf("ready_not_busy%0d", d),
              int'(req_ready[d]), int'(!busy[d]));
        if (resp_valid[d]) begin
          exp_t e;
          bit   have;
          have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
          if (!have) begin
            check($sformatf("unexpected_resp%0d", d), 1, 0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata%0d@%0d", d, e.acc),
                  int'(resp_rdata[d]), int'(e.rd));
            check($sformatf("error%0d@%0d", d, e.acc),
                  int'(resp_error[d]), int'(e.err));
            check($sformatf("latency%0d@%0d", d, e.acc),
                  cyc + 1 - e.acc, lat_of(d));
            check($sformatf("busy_in_resp%0d", d), int'(busy[d]), 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  initial begin
    int a1;
    int a2;
    for (int d = 0; d < 2; d++) begin
      reset[d]     = 1'b1;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_size[d]  = 2'd0;
      req_addr[d]  = 16'h0;
      req_wdata[d] = 16'h0;
      for (int i = 0; i < 256; i++) mm[d][i] = 8'h00;
    end
    repeat (3) tick();
    check("ready_in_reset0", int'(req_ready[0]), 0);
    check("ready_in_reset1", int'(req_ready[1]), 0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();
    check("rst_ready", int'(req_ready[0]), 1);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_resp_valid", int'(resp_valid[0]), 0);
    check("rst_rdata", int'(resp_rdata[0]), 0);
    check("rst_error", int'(resp_error[0]), 0);

    issue(0, 1, 2'd0, 16'h0002, 16'h1234, 1, a1);
    issue(0, 0, 2'd0, 16'h0002, 16'h0000, 1, a1);
    issue(0, 1, 2'd0, 16'h0004, 16'h5678, 1, a1);
    issue(0, 0, 2'd1, 16'h0004, 16'h0000, 1, a1);
    issue(0, 0, 2'd2, 16'h0005, 16'h0000, 1, a1);
    issue(0, 1, 2'd1, 16'h0006, 16'h00FF, 1, a1);
    issue(0, 0, 2'd2, 16'h0006, 16'h0000, 1, a1);
    issue(0, 0, 2'd1, 16'h0006, 16'h0000, 1, a1);
    issue(0, 1, 2'd2, 16'h0009, 16'hC3AB, 1, a1);
    issue(0, 0, 2'd0, 16'h0008, 16'h0000, 1, a1);
    issue(0, 0, 2'd1, 16'h0008, 16'h0000, 1, a1);
    issue(0, 0, 2'd0, 16'h0003, 16'h0000, 1, a1);
    issue(0, 1, 2'd0, 16'h00FF, 16'h1111, 1, a1);
    issue(0, 0, 2'd1, 16'h00FF, 16'h0000, 1, a1);
    issue(0, 0, 2'd1, 16'h0100, 16'h0000, 1, a1);
    issue(0, 0, 2'd3, 16'h0100, 16'h0000, 1, a1);
    issue(0, 0, 2'd3, 16'h00FE, 16'h0000, 1, a1);

    issue(0, 0, 2'd0, 16'h0002, 16'h0000, 1, a1);
    issue(0, 0, 2'd0, 16'h0004, 16'h0000, 1, a2);
    check("b2b_gap0", a2 - a1, 3);

    // Store dropped by reset while waiting
    issue(0, 1, 2'd0, 16'h0010, 16'hBEEF, 0, a1);
    check("busy_wait", int'(busy[0]), 1);
    reset[0] = 1'b1;
    tick();
    check("ready_mid_reset", int'(req_ready[0]), 0);
    reset[0] = 1'b0;
    tick();
    check("post_rst_ready", int'(req_ready[0]), 1);
    check("post_rst_busy", int'(busy[0]), 0);
    check("post_rst_valid", int'(resp_valid[0]), 0);
    check("post_rst_rdata", int'(resp_rdata[0]), 0);
    check("post_rst_error", int'(resp_error[0]), 0);
    issue(0, 0, 2'd0, 16'h0010, 16'h0000, 1, a1);

    issue(1, 1, 2'd0, 16'h0002, 16'h1234, 1, a1);
    issue(1, 0, 2'd0, 16'h0002, 16'h0000, 1, a2);
    check("b2b_gap1", a2 - a1, 2);
    drain();

    for (int i = 0; i < 160; i++) begin
      int        d;
      bit [15:0] ra;
      d  = i % 2;
      ra = (($urandom % 2) == 0) ? 16'($urandom_range(0, 31))
                                 : 16'($urandom_range(0, 16'h10F));
      issue(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ra, 16'($urandom), 1, a1);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
